// File: rtl/mul_issue_if.sv
// Handshake and multiplier-side signals for mul_issue_ctrl.
// slave = the controller; master = EXE/MEM/multiplier environment.
interface mul_issue_if #(
  parameter int TAG_W = 5
);
  // Valid/ready: a transfer happens on a clock edge where valid & ready are both 1;
  // the producer keeps its payload stable while valid & ~ready.
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [TAG_W-1:0] in_tag;

  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic             mul_signed;
  logic [63:0]      mul_result;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_tag, mul_result, out_ready,
    input  in_ready, mul_x, mul_y, mul_signed, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_tag, mul_result, out_ready,
    output in_ready, mul_x, mul_y, mul_signed, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Issue/writeback controller for the two-stage multiplier with a credit-gated result FIFO.
// Optional MUL_ISSUE_CTRL_PERF_EN adds completed-op and stall counters.
module mul_issue_ctrl #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 5
) (
  input  logic       mul_clk,
  input  logic       resetn,
  input  logic       flush,
  mul_issue_if.slave bus
`ifdef MUL_ISSUE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_done_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic             s1_valid_q, s1_valid_d;
  logic             s1_sel_hi_q, s1_sel_hi_d;
  logic [TAG_W-1:0] s1_tag_q, s1_tag_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];

  logic             issue, push, pop, out_valid_w;
  logic [CNT_W:0]   occ;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  assign out_valid_w = (count_q != '0);
  assign push        = s1_valid_q & ~flush;
  assign pop         = out_valid_w & bus.out_ready & ~flush;

  // Occupancy after this edge, counting the product still in the multiplier stage.
  assign occ = {1'b0, count_q} + {{CNT_W{1'b0}}, s1_valid_q} - {{CNT_W{1'b0}}, pop};
  assign bus.in_ready = ~flush & (occ < DEPTH_C);
  assign issue        = bus.in_valid & bus.in_ready & ~flush;

  assign bus.mul_x      = bus.in_src1;
  assign bus.mul_y      = bus.in_src2;
  assign bus.mul_signed = (bus.in_op == 2'b01);

  // Stale FIFO words are masked so idle outputs read as zero.
  assign bus.out_valid = out_valid_w;
  assign bus.out_data  = out_valid_w ? mem_q[rd_ptr_q].data : '0;
  assign bus.out_tag   = out_valid_w ? mem_q[rd_ptr_q].tag  : '0;

  always_comb begin
    s1_valid_d  = issue;
    s1_sel_hi_d = (bus.in_op == 2'b01) | (bus.in_op == 2'b10);
    s1_tag_d    = bus.in_tag;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    mem_d       = mem_q;

    if (push) begin
      mem_d[wr_ptr_q].data = s1_sel_hi_q ? bus.mul_result[63:32] : bus.mul_result[31:0];
      mem_d[wr_ptr_q].tag  = s1_tag_q;
      wr_ptr_d             = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count_q - CNT_W'(1);
    end

    if (flush) begin
      s1_valid_d = 1'b0;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end
  end

  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      s1_valid_q  <= 1'b0;
      s1_sel_hi_q <= 1'b0;
      s1_tag_q    <= '0;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sel_hi_q <= s1_sel_hi_d;
      s1_tag_q    <= s1_tag_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Storage is not reset; out_valid qualifies every read.
  always_ff @(posedge mul_clk) begin
    mem_q <= mem_d;
  end

`ifdef MUL_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_done_q, perf_done_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_done_d  = perf_done_q + (pop ? 32'd1 : 32'd0);
    perf_stall_d = perf_stall_q +
                   ((bus.in_valid & ~bus.in_ready & ~flush) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge mul_clk) begin
    if (!resetn) begin
      perf_done_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_done_q  <= perf_done_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_done_cnt  = perf_done_q;
  assign perf_stall_cnt = perf_stall_q;
`endif
endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: vector table for single ops plus
// hand-written back-to-back, stall, flush and mid-flight reset sequences.
module tb_mul_issue_ctrl;
  localparam int TAG_W = 5;
  localparam int DEPTH = 2;

  // ---------------- clock / reset ----------------
  logic mul_clk;
  logic resetn;
  logic flush;

  initial mul_clk = 1'b0;
  always #5 mul_clk = ~mul_clk;

  mul_issue_if #(.TAG_W(TAG_W)) bus ();

`ifdef MUL_ISSUE_CTRL_PERF_EN
  logic [31:0] perf_done_cnt;
  logic [31:0] perf_stall_cnt;
  int          pops_seen;
`endif

  mul_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .mul_clk (mul_clk),
    .resetn  (resetn),
    .flush   (flush),
    .bus     (bus)
`ifdef MUL_ISSUE_CTRL_PERF_EN
    ,
    .perf_done_cnt  (perf_done_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  // Multiplier model: one pipe register, no enable, cleared by resetn.
  logic [63:0] mul_prod;
  logic [63:0] mx_ext, my_ext;
  assign mx_ext = bus.mul_signed ? {{32{bus.mul_x[31]}}, bus.mul_x} : {32'd0, bus.mul_x};
  assign my_ext = bus.mul_signed ? {{32{bus.mul_y[31]}}, bus.mul_y} : {32'd0, bus.mul_y};
  always @(posedge mul_clk) begin
    if (!resetn) mul_prod <= '0;
    else         mul_prod <= mx_ext * my_ext;
  end
  assign bus.mul_result = mul_prod;

  // ---------------- bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [TAG_W+31:0] exp_q[$];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic drive_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_src1  = a;
    bus.in_src2  = b;
    bus.in_tag   = tag;
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
    bus.in_op    = 2'(($urandom_range(0, 3)));
    bus.in_src1  = $urandom;
    bus.in_src2  = $urandom;
    bus.in_tag   = TAG_W'($urandom_range(0, 31));
  endtask

  // One op with out_ready=1: accept, wait a cycle, result for one cycle, then idle.
  task automatic run_single(input string nm, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [TAG_W-1:0] tag,
                            input logic [31:0] exp, input logic exp_sgn);
    drive_op(op, a, b, tag);
    bus.out_ready = 1'b1;
    @(negedge mul_clk);
    check({nm, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({nm, "_mul_signed"}, 64'(bus.mul_signed), 64'(exp_sgn));
    check({nm, "_mul_x"}, 64'(bus.mul_x), 64'(a));
    check({nm, "_mul_y"}, 64'(bus.mul_y), 64'(b));
    if (bus.in_ready) exp_q.push_back({tag, exp});
    cyc();
    idle_in();
    @(negedge mul_clk);
    check({nm, "_early_valid"}, 64'(bus.out_valid), 64'd0);
    cyc();
    @(negedge mul_clk);
    check({nm, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({nm, "_out_data"}, 64'(bus.out_data), 64'(exp));
    check({nm, "_out_tag"}, 64'(bus.out_tag), 64'(tag));
    cyc();
    @(negedge mul_clk);
    check({nm, "_drained"}, 64'(bus.out_valid), 64'd0);
    cyc();
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge mul_clk) begin
`ifdef MUL_ISSUE_CTRL_PERF_EN
    if (!resetn) pops_seen = 0;
`endif
    if (resetn && !flush && bus.out_valid && bus.out_ready) begin
`ifdef MUL_ISSUE_CTRL_PERF_EN
      pops_seen++;
`endif
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual=tag 0x%0h data 0x%0h required=no output",
                 bus.out_tag, bus.out_data);
      end else begin
        check("sb_order", {28'd0, bus.out_tag, bus.out_data}, 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]       op;
    logic [31:0]      a;
    logic [31:0]      b;
    logic [TAG_W-1:0] tag;
    logic [31:0]      exp;
    logic             sgn;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 1'b0};
    vecs[1] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4,  32'h4000_0000, 1'b1};
    vecs[2] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, 1'b0};
    vecs[3] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'h0000_0000, 1'b1};
    vecs[4] = '{2'b11, 32'h0001_2345, 32'h0000_0010, 5'd31, 32'h0012_3450, 1'b0};
    vecs[5] = '{2'b00, 32'hFFFF_FFFF, 32'h0000_0002, 5'd12, 32'hFFFF_FFFE, 1'b0};
    vecs[6] = '{2'b10, 32'h8000_0000, 32'h0000_0002, 5'd13, 32'h0000_0001, 1'b0};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h0000_0002, 5'd14, 32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{2'b01, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5'd15, 32'h3FFF_FFFF, 1'b1};

    resetn        = 1'b0;
    flush         = 1'b0;
    bus.out_ready = 1'b0;
    idle_in();
    repeat (2) cyc();
    @(negedge mul_clk);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", 64'(bus.out_data), 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    cyc();
    resetn = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                 vecs[i].tag, vecs[i].exp, vecs[i].sgn);
    end

    // Back-to-back ops, tags 0..3, products 10,20,30,40.
    bus.out_ready = 1'b1;
    for (int t = 0; t < 7; t++) begin
      if (t < 4) drive_op(2'b00, 32'(t + 1), 32'd10, TAG_W'(t));
      else       idle_in();
      @(negedge mul_clk);
      if (t < 4) begin
        check($sformatf("b2b_in_ready%0d", t), 64'(bus.in_ready), 64'd1);
        if (bus.in_ready) exp_q.push_back({TAG_W'(t), 32'((t + 1) * 10)});
      end
      if (t >= 2 && t <= 5) begin
        check($sformatf("b2b_valid%0d", t), 64'(bus.out_valid), 64'd1);
        check($sformatf("b2b_tag%0d", t), 64'(bus.out_tag), 64'(t - 2));
        check($sformatf("b2b_data%0d", t), 64'(bus.out_data), 64'((t - 1) * 10));
      end
      if (t == 6) check("b2b_drained", 64'(bus.out_valid), 64'd0);
      cyc();
    end

    // Stall: A = MULH.WU 0x80000000*2 -> 1 (tag 5), B = MUL.W 3*5 -> 15 (tag 6).
    bus.out_ready = 1'b0;
    drive_op(2'b10, 32'h8000_0000, 32'd2, 5'd5);
    @(negedge mul_clk);
    check("stall_acc_a", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) exp_q.push_back({5'd5, 32'd1});
    cyc();
    drive_op(2'b00, 32'd3, 32'd5, 5'd6);
    @(negedge mul_clk);
    check("stall_acc_b", 64'(bus.in_ready), 64'd1);
    if (bus.in_ready) exp_q.push_back({5'd6, 32'd15});
    cyc();
    idle_in();
    for (int t = 0; t < 5; t++) begin
      @(negedge mul_clk);
      check($sformatf("stall_in_ready%0d", t), 64'(bus.in_ready), 64'd0);
      check($sformatf("stall_valid%0d", t), 64'(bus.out_valid), 64'd1);
      check($sformatf("stall_data%0d", t), 64'(bus.out_data), 64'd1);
      check($sformatf("stall_tag%0d", t), 64'(bus.out_tag), 64'd5);
      cyc();
    end
    bus.out_ready = 1'b1;
    @(negedge mul_clk);
    check("stall_release_ready", 64'(bus.in_ready), 64'd1);
    check("stall_head_a", 64'(bus.out_data), 64'd1);
    cyc();
    @(negedge mul_clk);
    check("stall_b_valid", 64'(bus.out_valid), 64'd1);
    check("stall_b_data", 64'(bus.out_data), 64'd15);
    check("stall_b_tag", 64'(bus.out_tag), 64'd6);
    check("stall_b_in_ready", 64'(bus.in_ready), 64'd1);
    cyc();
    @(negedge mul_clk);
    check("stall_drained", 64'(bus.out_valid), 64'd0);
    cyc();

    // Flush with one op buffered, one in the multiplier and a new op offered.
    bus.out_ready = 1'b0;
    drive_op(2'b00, 32'd4, 32'd5, 5'd10);
    @(negedge mul_clk);
    if (bus.in_ready) exp_q.push_back({5'd10, 32'd20});
    cyc();
    drive_op(2'b00, 32'd6, 32'd7, 5'd11);
    @(negedge mul_clk);
    if (bus.in_ready) exp_q.push_back({5'd11, 32'd42});
    cyc();
    drive_op(2'b00, 32'd8, 32'd9, 5'd12);
    flush = 1'b1;
    @(negedge mul_clk);
    check("flush_in_ready", 64'(bus.in_ready), 64'd0);
    check("flush_head_before", 64'(bus.out_valid), 64'd1);
    exp_q.delete();
    cyc();
    flush = 1'b0;
    idle_in();
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) begin
      @(negedge mul_clk);
      check($sformatf("flush_valid%0d", t), 64'(bus.out_valid), 64'd0);
      check($sformatf("flush_data%0d", t), 64'(bus.out_data), 64'd0);
      check($sformatf("flush_in_ready%0d", t), 64'(bus.in_ready), 64'd1);
      cyc();
    end
    run_single("after_flush", 2'b01, 32'hFFFF_FFFE, 32'd3, 5'd9, 32'hFFFF_FFFF, 1'b1);

    // Reset with two ops in flight.
    bus.out_ready = 1'b0;
    drive_op(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd20);
    @(negedge mul_clk);
    cyc();
    drive_op(2'b00, 32'd9, 32'd9, 5'd21);
    @(negedge mul_clk);
    cyc();
    idle_in();
    resetn = 1'b0;
    @(negedge mul_clk);
    exp_q.delete();
    cyc();
    resetn = 1'b1;
    @(negedge mul_clk);
    check("rst2_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst2_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst2_out_data", 64'(bus.out_data), 64'd0);
    check("rst2_out_tag", 64'(bus.out_tag), 64'd0);
    cyc();
    run_single("after_rst", 2'b00, 32'd2, 32'd3, 5'd1, 32'd6, 1'b0);

    repeat (2) cyc();
    check("sb_drain", 64'(exp_q.size()), 64'd0);
`ifdef MUL_ISSUE_CTRL_PERF_EN
    check("perf_done", 64'(perf_done_cnt), 64'(pops_seen));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
